adder_bist_driver: RTL and testbench
====================================

// Module: adder_bist_driver
// PURPOSE
//  On-chip stimulus/check engine for the 8-bit pin adder: it drives the other end of that adder's pin interface.
//  - Drives the operand pins (op_a -> ui_in, op_b -> uio_in) and samples the returned sum (uo_out -> sum_in).
//  - Compares each returned sum against an internally computed expected value.
//  - Reports the error count, pass/fail and the first failing vector.
// PARAMETERS
//  WIDTH          8      operand/sum width in bits
//  NUM_VECTORS    65536  vectors per run, 1..2^(2*WIDTH)
//  SETTLE_CYCLES  1      wait cycles between driving operands and sampling sum_in, 0..255
//  LFSR_SEED      16'hACE1  LFSR initial state; must be nonzero (used only with ADDER_BIST_LFSR_EN)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  start      in   1      run request, sampled in IDLE/DONE only
//  op_a       out  WIDTH  operand A (to ui_in), registered
//  op_b       out  WIDTH  operand B (to uio_in), registered
//  sum_in     in   WIDTH  sum returned by adder under test (uo_out)
//  busy       out  1      run in progress
//  done       out  1      run complete; held until next start or reset
//  pass       out  1      valid when done=1: 1 iff err_count==0
//  err_count  out  8      mismatch count, saturates at 8'hFF
//  fail_a     out  WIDTH  op_a of first mismatching vector
//  fail_b     out  WIDTH  op_b of first mismatching vector
//  fail_sum   out  WIDTH  sum_in of first mismatching vector
// BEHAVIOUR
//  - Reset: rst_n sampled low at a rising edge -> state IDLE; all outputs and idx/settle counters 0.
//    LFSR reloads LFSR_SEED. Applies mid-run; the run is discarded.
//  - FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
//  - IDLE/DONE + start=1:
//    - Clear err_count, done, pass, fail_*; idx=0; generator reset to vector 0.
//    - op_a/op_b <= vector 0; busy <= 1; next state DRIVE.
//  - start while busy=1 is ignored.
//  - DRIVE (1 cycle): operands stable on the pins.
//    - Load settle counter = SETTLE_CYCLES.
//    - Next state SETTLE if SETTLE_CYCLES>0, else CHECK.
//  - SETTLE: decrement the settle counter each cycle; reaching 0 -> CHECK.
//  - CHECK (1 cycle): sample sum_in and compare with expected = (op_a + op_b) mod 2^WIDTH; the carry is discarded.
//    - Mismatch: err_count += 1, saturating at 8'hFF.
//    - If this is the first mismatch of the run: capture fail_a/fail_b/fail_sum.
//    - If idx == NUM_VECTORS-1: next state DONE; busy<=0, done<=1, pass<=(final err_count==0).
//    - Otherwise: idx+=1, advance generator, op_a/op_b <= next vector, next state DRIVE.
//  - Timing:
//    - Per vector: SETTLE_CYCLES+2 cycles.
//    - done rises NUM_VECTORS*(SETTLE_CYCLES+2)+1 cycles after the start sample edge.
//  - op_a/op_b hold their value for the full DRIVE..CHECK window. After DONE they hold the last vector.
//  - The idx counter is 2*WIDTH+1 bits wide so NUM_VECTORS = 2^(2*WIDTH) terminates without wrap.
//  - DONE + start=1 behaves exactly as IDLE + start=1 (restart).
// CONFIGURATION
//  ADDER_BIST_LFSR_EN undefined (default):
//    - Exhaustive sweep: {op_b, op_a} = idx[2*WIDTH-1:0].
//    - Vector 0 = (0,0), vector 1 = (1,0), ..., vector 256 = (0,1).
//  ADDER_BIST_LFSR_EN defined:
//    - {op_b, op_a} = state of a 16-bit Fibonacci LFSR, seeded LFSR_SEED at run start.
//    - Update: fb = s[15]^s[13]^s[12]^s[10]; s <= {s[14:0], fb}.
//    - Requires WIDTH=8; the LFSR never reaches state 0.
// TESTING
//  1. Loopback through a correct adder, NUM_VECTORS=4, SETTLE=1, start pulse:
//     -> vectors (0,0),(1,0),(2,0),(3,0); done=1 exactly 13 cycles after start; pass=1; err_count=0.
//  2. sum_in forced 8'h00, NUM_VECTORS=4:
//     -> err_count=3, pass=0, fail_a=8'h01, fail_b=8'h00, fail_sum=8'h00.
//  3. Exhaustive NUM_VECTORS=65536 with correct adder:
//     -> vector (FF,FF) expects 8'hFE (carry dropped); pass=1.
//     Same run with sum_in = 8'h00 constant -> err_count saturates at 8'hFF.
//  4. rst_n low 1 cycle while busy during vector 2:
//     -> next edge: IDLE, all outputs 0.
//     New start -> sequence restarts at (0,0).
//  5. start pulses while busy:
//     -> no effect on idx/err_count.
//     start in DONE after a failing run -> err_count, fail_*, pass, done cleared; new run proceeds.
//  6. With ADDER_BIST_LFSR_EN, seed 16'hACE1:
//     -> vector 0 op_a=8'hE1 op_b=8'hAC; vector 1 op_a=8'hC3 op_b=8'h59; loopback pass=1.

Source files
------------

// File: rtl/adder_bist_driver.sv
// Stimulus/check engine for the 8-bit pin adder: drives operands, samples the sum, and logs mismatches.
// Optional feature macro: ADDER_BIST_LFSR_EN selects a 16-bit LFSR pattern source instead of the exhaustive sweep.
module adder_bist_driver #(
  parameter int          WIDTH         = 8,
  parameter int          NUM_VECTORS   = 65536,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] sum_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_sum
);

  localparam int             IDXW        = 2*WIDTH + 1;
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_VECTORS - 1);
  localparam logic [7:0]     SETTLE_LOAD = 8'(SETTLE_CYCLES);

  // Elaboration-time guards on the parameter ranges.
  if (NUM_VECTORS < 1 || NUM_VECTORS > (1 << (2*WIDTH))) begin : g_bad_num_vectors
    $error("adder_bist_driver: NUM_VECTORS out of range");
  end
  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("adder_bist_driver: SETTLE_CYCLES out of range");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("adder_bist_driver: LFSR_SEED must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [7:0]       settle_q, settle_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic [WIDTH-1:0] fail_sum_q, fail_sum_d;

  logic [IDXW-1:0]  idx_next;
  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic [7:0]       err_inc;
  logic [WIDTH-1:0] first_a, first_b, next_a, next_b;

`ifdef ADDER_BIST_LFSR_EN
  // Pattern source is a 16-bit Fibonacci LFSR; only meaningful for WIDTH=8.
  logic [15:0] lfsr_q, lfsr_d, lfsr_next;

  always_comb begin
    lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    first_a   = LFSR_SEED[WIDTH-1:0];
    first_b   = LFSR_SEED[2*WIDTH-1:WIDTH];
    next_a    = lfsr_next[WIDTH-1:0];
    next_b    = lfsr_next[2*WIDTH-1:WIDTH];
  end
`else
  always_comb begin
    first_a = '0;
    first_b = '0;
    next_a  = idx_next[WIDTH-1:0];
    next_b  = idx_next[2*WIDTH-1:WIDTH];
  end
`endif

  always_comb begin
    idx_next = idx_q + 1'b1;
    expected = op_a_q + op_b_q;
    mismatch = (sum_in != expected);
    err_inc  = err_q;
    if (mismatch && err_q != 8'hFF) begin
      err_inc = err_q + 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_sum_d = fail_sum_q;
`ifdef ADDER_BIST_LFSR_EN
    lfsr_d     = lfsr_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        // done is registered off the DONE state, so it rises one cycle after busy falls.
        if (state_q == S_DONE) begin
          done_d = 1'b1;
        end
        if (start) begin
          err_d      = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_a_d   = '0;
          fail_b_d   = '0;
          fail_sum_d = '0;
          idx_d      = '0;
          op_a_d     = first_a;
          op_b_d     = first_b;
          busy_d     = 1'b1;
`ifdef ADDER_BIST_LFSR_EN
          lfsr_d     = LFSR_SEED;
`endif
          state_d    = S_DRIVE;
        end
      end

      S_DRIVE: begin
        settle_d = SETTLE_LOAD;
        state_d  = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
      end

      S_SETTLE: begin
        settle_d = settle_q - 8'd1;
        if (settle_q == 8'd1) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        err_d = err_inc;
        if (mismatch && err_q == 8'h00) begin
          fail_a_d   = op_a_q;
          fail_b_d   = op_b_q;
          fail_sum_d = sum_in;
        end
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          pass_d  = (err_inc == 8'h00);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_next;
          op_a_d  = next_a;
          op_b_d  = next_b;
`ifdef ADDER_BIST_LFSR_EN
          lfsr_d  = lfsr_next;
`endif
          state_d = S_DRIVE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_sum_q <= '0;
`ifdef ADDER_BIST_LFSR_EN
      lfsr_q     <= LFSR_SEED;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_sum_q <= fail_sum_d;
`ifdef ADDER_BIST_LFSR_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_sum  = fail_sum_q;

endmodule

// File: tb/tb_adder_bist_driver.sv
// Directed bench for adder_bist_driver: a 4-vector instance (settle 1) and a 512-vector instance (settle 0).
module tb_adder_bist_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       force_a = 1'b0, force_b = 1'b0;

  logic [7:0] op_a_a, op_b_a, sum_a, err_a, fa_a, fb_a, fs_a;
  logic       busy_a, done_a, pass_a;
  logic [7:0] op_a_b, op_b_b, sum_b, err_b, fa_b, fb_b, fs_b;
  logic       busy_b, done_b, pass_b;

  int n_vec = 0;
  int n_err = 0;

  // Expected vectors {op_b, op_a} and first-failure data for each pattern source.
`ifdef ADDER_BIST_LFSR_EN
  logic [15:0] exp_vec [4] = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F};
  localparam logic [7:0] ZERO_ERRS_A = 8'd4;
`else
  logic [15:0] exp_vec [4] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
  localparam logic [7:0] ZERO_ERRS_A = 8'd3;
`endif

  always #5 clk = ~clk;

  // Reference adders on the pin side; carry is dropped by the 8-bit result.
  assign sum_a = force_a ? 8'h00 : 8'(op_a_a + op_b_a);
  assign sum_b = force_b ? 8'h00 : 8'(op_a_b + op_b_b);

  adder_bist_driver #(.WIDTH(8), .NUM_VECTORS(4), .SETTLE_CYCLES(1), .LFSR_SEED(16'hACE1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .op_a(op_a_a), .op_b(op_b_a), .sum_in(sum_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_a(fa_a), .fail_b(fb_a), .fail_sum(fs_a));

  adder_bist_driver #(.WIDTH(8), .NUM_VECTORS(512), .SETTLE_CYCLES(0), .LFSR_SEED(16'hACE1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op_a(op_a_b), .op_b(op_b_b), .sum_in(sum_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_a(fa_b), .fail_b(fb_b), .fail_sum(fs_b));

  task automatic kick_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  task automatic kick_b();
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int max, output int cyc);
    cyc = 0;
    while (done_a !== 1'b1 && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({op_a_a, op_b_a, busy_a, done_a, pass_a, err_a, fa_a, fb_a, fs_a} !== '0) begin
      n_err++;
      $display("FAIL reset_a: got %h required 0",
               {op_a_a, op_b_a, busy_a, done_a, pass_a, err_a, fa_a, fb_a, fs_a});
    end
    n_vec++;
    if ({op_a_b, op_b_b, busy_b, done_b, pass_b, err_b, fa_b, fb_b, fs_b} !== '0) begin
      n_err++;
      $display("FAIL reset_b: got %h required 0",
               {op_a_b, op_b_b, busy_b, done_b, pass_b, err_b, fa_b, fb_b, fs_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loopback();
    int c;
    force_a = 1'b0;
    kick_a();
    n_vec++;
    if ({busy_a, op_b_a, op_a_a} !== {1'b1, exp_vec[0]}) begin
      n_err++;
      $display("FAIL loop_vec0: got busy=%b vec=%h required busy=1 vec=%h", busy_a, {op_b_a, op_a_a}, exp_vec[0]);
    end
    c = 0;
    while (done_a !== 1'b1 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (c == 3 || c == 6 || c == 9) begin
        n_vec++;
        if ({op_b_a, op_a_a} !== exp_vec[c/3]) begin
          n_err++;
          $display("FAIL loop_vec%0d: got %h required %h", c/3, {op_b_a, op_a_a}, exp_vec[c/3]);
        end
      end
    end
    n_vec++;
    if (c !== 13) begin
      n_err++;
      $display("FAIL loop_done_time: got %0d cycles required 13", c);
    end
    n_vec++;
    if ({pass_a, busy_a, err_a, op_b_a, op_a_a} !== {1'b1, 1'b0, 8'h00, exp_vec[3]}) begin
      n_err++;
      $display("FAIL loop_result: got pass=%b busy=%b err=%h vec=%h required pass=1 busy=0 err=00 vec=%h",
               pass_a, busy_a, err_a, {op_b_a, op_a_a}, exp_vec[3]);
    end
  endtask

  task automatic test_force_zero();
    int c;
    force_a = 1'b1;
    kick_a();
    wait_done_a(40, c);
    n_vec++;
    if (c !== 13) begin
      n_err++;
      $display("FAIL zero_done_time: got %0d cycles required 13", c);
    end
    n_vec++;
    if ({err_a, pass_a} !== {ZERO_ERRS_A, 1'b0}) begin
      n_err++;
      $display("FAIL zero_err: got err=%h pass=%b required err=%h pass=0", err_a, pass_a, ZERO_ERRS_A);
    end
    n_vec++;
`ifdef ADDER_BIST_LFSR_EN
    if ({fa_a, fb_a, fs_a} !== 24'hE1_AC_00) begin
`else
    if ({fa_a, fb_a, fs_a} !== 24'h01_00_00) begin
`endif
      n_err++;
      $display("FAIL zero_first_fail: got a=%h b=%h sum=%h", fa_a, fb_a, fs_a);
    end
  endtask

  task automatic test_start_busy();
    int c;
    force_a = 1'b1;
    kick_a();
    c = 0;
    while (done_a !== 1'b1 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      start_a = (c == 4 || c == 7 || c == 8);
    end
    start_a = 1'b0;
    n_vec++;
    if (c !== 13) begin
      n_err++;
      $display("FAIL busy_start_time: got %0d cycles required 13", c);
    end
    n_vec++;
    if (err_a !== ZERO_ERRS_A) begin
      n_err++;
      $display("FAIL busy_start_err: got %h required %h", err_a, ZERO_ERRS_A);
    end
    // Restart out of DONE after the failing run.
    force_a = 1'b0;
    kick_a();
    n_vec++;
    if ({busy_a, done_a, pass_a, err_a, fa_a, fb_a, fs_a, op_b_a, op_a_a} !== {3'b100, 32'h0, exp_vec[0]}) begin
      n_err++;
      $display("FAIL restart_clear: got busy=%b done=%b pass=%b err=%h fail=%h%h%h vec=%h", busy_a, done_a, pass_a,
               err_a, fa_a, fb_a, fs_a, {op_b_a, op_a_a});
    end
    wait_done_a(40, c);
    n_vec++;
    if ({c == 13, pass_a, err_a} !== {2'b11, 8'h00}) begin
      n_err++;
      $display("FAIL restart_run: got cycles=%0d pass=%b err=%h required 13/1/00", c, pass_a, err_a);
    end
  endtask

  task automatic test_reset_midrun();
    int c;
    force_a = 1'b0;
    kick_a();
    c = 0;
    while (c < 7) begin
      @(posedge clk);
      #1;
      c++;
    end
    n_vec++;
    if ({op_b_a, op_a_a} !== exp_vec[2]) begin
      n_err++;
      $display("FAIL midrun_vec2: got %h required %h", {op_b_a, op_a_a}, exp_vec[2]);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_vec++;
    if ({op_a_a, op_b_a, busy_a, done_a, pass_a, err_a, fa_a, fb_a, fs_a} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: got %h required 0",
               {op_a_a, op_b_a, busy_a, done_a, pass_a, err_a, fa_a, fb_a, fs_a});
    end
    kick_a();
    n_vec++;
    if ({busy_a, op_b_a, op_a_a} !== {1'b1, exp_vec[0]}) begin
      n_err++;
      $display("FAIL midrun_restart: got busy=%b vec=%h required busy=1 vec=%h", busy_a, {op_b_a, op_a_a}, exp_vec[0]);
    end
    wait_done_a(40, c);
    n_vec++;
    if ({c == 13, pass_a} !== 2'b11) begin
      n_err++;
      $display("FAIL midrun_run: got cycles=%0d pass=%b required 13/1", c, pass_a);
    end
  endtask

  task automatic test_exhaustive();
    int c;
    force_b = 1'b0;
    kick_b();
    c = 0;
    while (done_b !== 1'b1 && c < 1200) begin
      @(posedge clk);
      #1;
      c++;
`ifndef ADDER_BIST_LFSR_EN
      if (c == 510 || c == 512) begin
        n_vec++;
        if ({op_b_b, op_a_b} !== ((c == 510) ? 16'h00FF : 16'h0100)) begin
          n_err++;
          $display("FAIL sweep_vec_at_%0d: got %h", c, {op_b_b, op_a_b});
        end
      end
`endif
    end
    n_vec++;
    if (c !== 1025) begin
      n_err++;
      $display("FAIL sweep_done_time: got %0d cycles required 1025", c);
    end
    n_vec++;
    if ({pass_b, err_b} !== {1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL sweep_pass: got pass=%b err=%h required 1/00", pass_b, err_b);
    end
    force_b = 1'b1;
    kick_b();
    c = 0;
    while (done_b !== 1'b1 && c < 1200) begin
      @(posedge clk);
      #1;
      c++;
    end
    n_vec++;
    if ({c == 1025, pass_b, err_b} !== {2'b10, 8'hFF}) begin
      n_err++;
      $display("FAIL sweep_saturate: got cycles=%0d pass=%b err=%h required 1025/0/FF", c, pass_b, err_b);
    end
    n_vec++;
`ifdef ADDER_BIST_LFSR_EN
    if ({fa_b, fb_b, fs_b} !== 24'hE1_AC_00) begin
`else
    if ({fa_b, fb_b, fs_b} !== 24'h01_00_00) begin
`endif
      n_err++;
      $display("FAIL sweep_first_fail: got a=%h b=%h sum=%h", fa_b, fb_b, fs_b);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_force_zero();
    test_start_busy();
    test_reset_midrun();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
